// File: rtl/keypad_entry_encoder_pkg.sv
// Shared definitions for the timer entry path: BCD width, default sizes and
// the key-qualification state encoding.
package keypad_entry_encoder_pkg;

    localparam int BCD_W          = 4;
    localparam int NUM_KEYS_DEF   = 10;
    localparam int MAX_DIGITS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SETTLE       = 2'd1,
        ACCEPT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/keypad_entry_encoder_if.sv
// Keypad entry bus: raw keys and cancel in, settle counter handshake,
// accepted digit stream and entry register out.
interface keypad_entry_encoder_if
    import keypad_entry_encoder_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DEF,
    parameter int MAX_DIGITS = MAX_DIGITS_DEF
);

    logic [NUM_KEYS-1:0]               key;
    logic                              cancel;
    logic                              settle_clear;
    logic                              settle_done;
    logic [BCD_W-1:0]                  digit;
    logic                              digit_valid;
    logic                              multi_key;
    logic                              overflow;
    logic [BCD_W*MAX_DIGITS-1:0]       entry_bcd;
    logic [$clog2(MAX_DIGITS+1)-1:0]   entry_count;

    // Environment side: keypad, cancel button and the settle counter.
    modport master (
        output key,
        output cancel,
        output settle_done,
        input  settle_clear,
        input  digit,
        input  digit_valid,
        input  multi_key,
        input  overflow,
        input  entry_bcd,
        input  entry_count
    );

    // Encoder side.
    modport slave (
        input  key,
        input  cancel,
        input  settle_done,
        output settle_clear,
        output digit,
        output digit_valid,
        output multi_key,
        output overflow,
        output entry_bcd,
        output entry_count
    );

endinterface

// File: rtl/keypad_onehot_to_bcd.sv
// Combinational decode of a key snapshot: BCD index of the set bit, a flag
// for exactly one key and a flag for two or more keys.
module keypad_onehot_to_bcd
    import keypad_entry_encoder_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_DEF
) (
    input  logic [NUM_KEYS-1:0] snapshot,
    output logic [BCD_W-1:0]    index,
    output logic                one_hot,
    output logic                multi_hot
);

    localparam int CNT_W = $clog2(NUM_KEYS + 1);

    logic [CNT_W-1:0] bits_set;

    // Count set bits and remember the index of the highest one; the index is
    // only meaningful when exactly one bit is set.
    always_comb begin
        bits_set = '0;
        index    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (snapshot[i]) begin
                bits_set = bits_set + CNT_W'(1);
                index    = BCD_W'(i);
            end
        end
    end

    assign one_hot   = (bits_set == CNT_W'(1));
    assign multi_hot = (bits_set >  CNT_W'(1));

endmodule

// File: rtl/keypad_entry_encoder.sv
// Keypad front end: qualifies raw key presses against an external settle
// counter, emits one BCD digit per press and shifts accepted digits into a
// saturating MM:SS entry register.
module keypad_entry_encoder
    import keypad_entry_encoder_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DEF,
    parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic                   clock,
    input  logic                   clear,
    keypad_entry_encoder_if.slave  bus
);

    localparam int ENTRY_W = BCD_W * MAX_DIGITS;
    localparam int CNT_W   = $clog2(MAX_DIGITS + 1);

    state_t                state, state_nxt;
    logic [NUM_KEYS-1:0]   snapshot, snapshot_nxt;
    logic                  settle_clear_q, settle_clear_nxt;

    logic [BCD_W-1:0]      dec_index;
    logic                  dec_one_hot;
    logic                  dec_multi_hot;

    logic [BCD_W-1:0]      digit_q;
    logic                  digit_valid_q;
    logic                  multi_key_q;
    logic                  overflow_q;
    logic [ENTRY_W-1:0]    entry_bcd_q;
    logic [CNT_W-1:0]      entry_count_q;

    logic                  key_any;
    logic                  key_match;
    logic                  take_digit;

    // Entry register is full once it holds MAX_DIGITS digits.
    function automatic logic entry_full(input logic [CNT_W-1:0] count);
        return count >= CNT_W'(MAX_DIGITS);
    endfunction

    // Shift a new digit in at the least significant end.
    function automatic logic [ENTRY_W-1:0] entry_shift(
        input logic [ENTRY_W-1:0] entry,
        input logic [BCD_W-1:0]   new_digit
    );
        return {entry[ENTRY_W-BCD_W-1:0], new_digit};
    endfunction

    keypad_onehot_to_bcd #(
        .NUM_KEYS (NUM_KEYS)
    ) u_decode (
        .snapshot  (snapshot),
        .index     (dec_index),
        .one_hot   (dec_one_hot),
        .multi_hot (dec_multi_hot)
    );

    assign key_any    = |bus.key;
    assign key_match  = (bus.key == snapshot);
    assign take_digit = (state == ACCEPT) && dec_one_hot;

    // FSM register together with the key snapshot and the registered
    // settle counter clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state          <= IDLE;
            snapshot       <= '0;
            settle_clear_q <= 1'b1;
        end else begin
            state          <= state_nxt;
            snapshot       <= snapshot_nxt;
            settle_clear_q <= settle_clear_nxt;
        end
    end

    // Next-state logic: the settle counter is held clear except while a
    // stable press is being qualified; any change of the key pattern re-arms
    // it. settle_done is trusted only while the clear is released, because
    // in the cycle after a re-arm it still shows the old count.
    always_comb begin
        state_nxt        = state;
        snapshot_nxt     = snapshot;
        settle_clear_nxt = 1'b1;
        case (state)
            IDLE: begin
                if (key_any) begin
                    snapshot_nxt     = bus.key;
                    settle_clear_nxt = 1'b0;
                    state_nxt        = SETTLE;
                end
            end
            SETTLE: begin
                if (!key_any) begin
                    state_nxt        = IDLE;
                end else if (!key_match) begin
                    snapshot_nxt     = bus.key;
                    settle_clear_nxt = 1'b1;
                end else if (bus.settle_done && !settle_clear_q) begin
                    settle_clear_nxt = 1'b0;
                    state_nxt        = ACCEPT;
                end else begin
                    settle_clear_nxt = 1'b0;
                end
            end
            ACCEPT: begin
                state_nxt = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!key_any) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Digit output and one-cycle status pulses, produced in the ACCEPT cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            multi_key_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            digit_valid_q <= 1'b0;
            multi_key_q   <= 1'b0;
            overflow_q    <= 1'b0;
            if (take_digit) begin
                digit_q       <= dec_index;
                digit_valid_q <= 1'b1;
                overflow_q    <= entry_full(entry_count_q);
            end else if ((state == ACCEPT) && dec_multi_hot) begin
                multi_key_q   <= 1'b1;
            end
        end
    end

    // Entry shift register; cancel wins over a digit arriving in the same
    // cycle, and a full register ignores further digits.
    always_ff @(posedge clock) begin
        if (clear || bus.cancel) begin
            entry_bcd_q   <= '0;
            entry_count_q <= '0;
        end else if (take_digit && !entry_full(entry_count_q)) begin
            entry_bcd_q   <= entry_shift(entry_bcd_q, dec_index);
            entry_count_q <= entry_count_q + CNT_W'(1);
        end
    end

    assign bus.settle_clear = settle_clear_q;
    assign bus.digit        = digit_q;
    assign bus.digit_valid  = digit_valid_q;
    assign bus.multi_key    = multi_key_q;
    assign bus.overflow     = overflow_q;
    assign bus.entry_bcd    = entry_bcd_q;
    assign bus.entry_count  = entry_count_q;

endmodule

// File: tb/tb_keypad_entry_encoder.sv
// Bench for keypad_entry_encoder with a behavioural settle counter attached.
module tb_keypad_entry_encoder;

    typedef struct {
        logic [3:0]  d;
        logic        ovf;
        logic [15:0] e;
        logic [2:0]  c;
    } exp_t;

    logic clock;
    logic clear;

    keypad_entry_encoder_if #(.NUM_KEYS(10), .MAX_DIGITS(4)) bus ();

    keypad_entry_encoder #(
        .NUM_KEYS   (10),
        .MAX_DIGITS (4)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    int          multi_exp = 0;
    logic [15:0] m_entry = '0;
    int          m_count = 0;
    int          lat;
    logic [2:0]  sc_cnt = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream non-recycling settle counter: saturates at 4.
    always @(posedge clock) begin
        if (bus.settle_clear) sc_cnt <= '0;
        else if (sc_cnt != 3'd4) sc_cnt <= sc_cnt + 3'd1;
    end
    assign bus.settle_done = (sc_cnt == 3'd4);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [9:0] key_of(input int d);
        logic [9:0] k;
        k = 10'd1;
        return k << d;
    endfunction

    task automatic expect_digit(input int d);
        exp_t e;
        e.d = 4'(d);
        if (m_count < 4) begin
            m_entry = {m_entry[11:0], 4'(d)};
            m_count++;
            e.ovf = 1'b0;
        end else begin
            e.ovf = 1'b1;
        end
        e.e = m_entry;
        e.c = 3'(m_count);
        sbq.push_back(e);
    endtask

    // Count edges after the sampling edge until digit_valid is seen.
    task automatic wait_dv(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.digit_valid) begin
                n = i;
                break;
            end
        end
        if (n == 0) check("dv_timeout", 32'd0, 32'd1);
    endtask

    task automatic press(input int d, input int hold);
        bus.key = key_of(d);
        repeat (hold) tick();
        bus.key = '0;
        repeat (3) tick();
    endtask

    task automatic do_cancel();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        m_entry = '0;
        m_count = 0;
        check("cancel_entry", 32'(bus.entry_bcd), 32'h0);
        check("cancel_count", 32'(bus.entry_count), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_settle_clear"}, 32'(bus.settle_clear), 32'd1);
        check({tag, "_digit"},        32'(bus.digit),        32'd0);
        check({tag, "_digit_valid"},  32'(bus.digit_valid),  32'd0);
        check({tag, "_multi_key"},    32'(bus.multi_key),    32'd0);
        check({tag, "_overflow"},     32'(bus.overflow),     32'd0);
        check({tag, "_entry_bcd"},    32'(bus.entry_bcd),    32'd0);
        check({tag, "_entry_count"},  32'(bus.entry_count),  32'd0);
    endtask

    // Scoreboard monitor: every pulse must match a queued expectation.
    always @(negedge clock) begin
        if (bus.digit_valid) begin
            if (sbq.size() == 0) begin
                check("dv_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("digit",       32'(bus.digit),       32'(mon_e.d));
                check("overflow",    32'(bus.overflow),    32'(mon_e.ovf));
                check("entry_bcd",   32'(bus.entry_bcd),   32'(mon_e.e));
                check("entry_count", 32'(bus.entry_count), 32'(mon_e.c));
            end
        end else if (bus.overflow) begin
            check("overflow_without_dv", 32'd1, 32'd0);
        end
        if (bus.multi_key) begin
            check("multi_expected", 32'(multi_exp > 0), 32'd1);
            if (multi_exp > 0) multi_exp--;
            check("multi_no_dv",  32'(bus.digit_valid), 32'd0);
            check("multi_entry",  32'(bus.entry_bcd),   32'(m_entry));
        end
    end

    initial begin
        clear      = 1'b1;
        bus.key    = '0;
        bus.cancel = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        clear = 1'b0;
        repeat (2) tick();
        check("idle_settle_clear", 32'(bus.settle_clear), 32'd1);

        // Clean press of digit 2, held 10 cycles.
        expect_digit(2);
        bus.key = key_of(2);
        tick();
        check("press_settle_clear_falls", 32'(bus.settle_clear), 32'd0);
        wait_dv(lat);
        check("clean_latency", 32'(lat), 32'd6);
        check("clean_entry", 32'(bus.entry_bcd), 32'h0002);
        repeat (3) tick();
        check("hold_settle_clear", 32'(bus.settle_clear), 32'd1);
        bus.key = '0;
        repeat (3) tick();

        // Bounce: 8, C, 8, 0 then stable 8 -> one digit 3.
        expect_digit(3);
        bus.key = 10'h008; tick();
        check("bounce_sc0", 32'(bus.settle_clear), 32'd0);
        bus.key = 10'h00C; tick();
        check("bounce_sc1", 32'(bus.settle_clear), 32'd1);
        bus.key = 10'h008; tick();
        check("bounce_sc2", 32'(bus.settle_clear), 32'd1);
        bus.key = 10'h000; tick();
        check("bounce_sc3", 32'(bus.settle_clear), 32'd1);
        bus.key = 10'h008; tick();
        check("bounce_sc4", 32'(bus.settle_clear), 32'd0);
        wait_dv(lat);
        check("bounce_latency", 32'(lat), 32'd6);
        repeat (8) tick();
        bus.key = '0;
        repeat (3) tick();
        check("bounce_entry", 32'(bus.entry_bcd), 32'h0023);

        // Multi-key press: no digit, entry unchanged.
        multi_exp = 1;
        bus.key = 10'h021;
        repeat (12) tick();
        bus.key = '0;
        repeat (3) tick();
        check("multi_consumed", 32'(multi_exp), 32'd0);
        check("multi_entry_after", 32'(bus.entry_bcd), 32'h0023);

        // Fill and overflow.
        do_cancel();
        for (int d = 1; d <= 4; d++) begin
            expect_digit(d);
            press(d, 9);
        end
        check("fill_entry", 32'(bus.entry_bcd), 32'h1234);
        check("fill_count", 32'(bus.entry_count), 32'd4);
        expect_digit(5);
        press(5, 9);
        check("ovf_entry", 32'(bus.entry_bcd), 32'h1234);
        check("ovf_count", 32'(bus.entry_count), 32'd4);

        // Cancel of a partial entry.
        do_cancel();
        expect_digit(1); press(1, 9);
        expect_digit(2); press(2, 9);
        check("partial_entry", 32'(bus.entry_bcd), 32'h0012);
        do_cancel();

        // Cancel coinciding with the ACCEPT of digit 7.
        sbq.push_back('{d: 4'd7, ovf: 1'b0, e: 16'h0, c: 3'd0});
        bus.key = key_of(7);
        tick();
        repeat (5) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cancel_accept_dv", 32'(bus.digit_valid), 32'd1);
        check("cancel_accept_digit", 32'(bus.digit), 32'd7);
        check("cancel_accept_entry", 32'(bus.entry_bcd), 32'h0);
        repeat (4) tick();
        bus.key = '0;
        repeat (3) tick();

        // Reset two cycles into a press of digit 5.
        bus.key = key_of(5);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.key = '0;
        m_entry = '0;
        m_count = 0;
        check_reset_outputs("midreset");
        repeat (10) tick();

        // Press after reset behaves like the clean case.
        expect_digit(2);
        bus.key = key_of(2);
        tick();
        check("repress_settle_clear", 32'(bus.settle_clear), 32'd0);
        wait_dv(lat);
        check("repress_latency", 32'(lat), 32'd6);
        repeat (4) tick();
        bus.key = '0;
        repeat (3) tick();
        check("repress_entry", 32'(bus.entry_bcd), 32'h0002);
        check("repress_count", 32'(bus.entry_count), 32'd1);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        check("multi_pending", 32'(multi_exp), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
